biriscv_branch_resolve: RTL and testbench
=========================================

Name: biriscv_branch_resolve

Overview:
- Sits between the dual execute pipes and the next-PC predictor; it is the producer of the predictor's branch update/redirect interface.
- Compares each resolved branch's actual outcome against the prediction carried down the pipe.
- Issues an immediate redirect and training request on a mispredict.
- Queues correctly predicted resolutions and replays them one per cycle as training-only updates.

Parameters:
- QUEUE_DEPTH, 4, training queue entries (power of 2, >=2)
- QUEUE_DEPTH_W, 2, log2(QUEUE_DEPTH)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  squash this cycle's pipe inputs (wrong-path)
- pipeN_valid_i (N=0,1)  in  1  branch resolved this cycle in pipe N; pipe0 is always older than pipe1
- pipeN_source_i  in  32  PC of the branch
- pipeN_taken_i  in  1  actual outcome is taken
- pipeN_target_i  in  32  actual target, meaningful when taken
- pipeN_is_call_i / pipeN_is_ret_i / pipeN_is_jmp_i  in  1 each  branch type
- pipeN_pred_taken_i  in  1  fetch predicted taken
- pipeN_pred_target_i  in  32  fetch predicted target
- branch_request_o  out  1  mispredict: redirect fetch and train
- branch_is_taken_o  out  1  training: taken
- branch_is_not_taken_o  out  1  training: not taken
- branch_source_o  out  32  branch PC
- branch_pc_o  out  32  redirect PC (target if taken, else source+4)
- branch_is_call_o / branch_is_ret_o / branch_is_jmp_o  out  1 each  type
- queue_drop_o  out  1  pulse: a training entry was discarded because the queue was full

Behaviour:
- All outputs are registered, with 1-cycle latency from the inputs. Reset value of every output is 0.
- Mispredict for pipe N: valid & ~flush & (taken != pred_taken | (taken & target != pred_target)).
- Precedence for older/younger pipes:
  - If pipe0 mispredicts, pipe1 is squashed: not queued, not emitted.
  - If pipe0 is correct and pipe1 mispredicts, pipe0 is pushed to the queue and pipe1 is emitted.
  - At most one mispredict is emitted per cycle, and it is the oldest.
- Output slot each cycle, in priority order:
  - A mispredict from the previous cycle's inputs: branch_request_o=1, taken/not_taken from the actual outcome, all fields valid.
  - Otherwise, pop the queue head: branch_request_o=0, exactly one of taken/not_taken=1, branch_pc_o = actual target or source+4.
  - Otherwise, all strobes 0. Data fields hold their last value.
- Queue: circular buffer with read/write pointers and a count.
  - Up to 2 pushes per cycle, in order pipe0 then pipe1. Up to 1 pop per cycle.
  - A pop is blocked in a cycle where a mispredict occupies the output slot.
  - Push and pop in the same cycle are legal; the count updates by the net change.
  - Full: a push that would exceed QUEUE_DEPTH after accounting for the same-cycle pop is dropped. The younger entry (pipe1) drops first. queue_drop_o=1 next cycle.
  - Empty: no pop; strobes low.
  - Pointers wrap modulo QUEUE_DEPTH.
- A mispredict never enters the queue and is never dropped. Queued entries are older and are emitted after it.
- flush_i: this cycle's inputs are ignored. Queue contents and the in-flight output are retained.
- Reset mid-operation clears pointers, count and outputs in the same edge. Queue data contents are don't-care.
- branch_pc_o arithmetic: 32-bit wrap, so source 32'hFFFFFFFC + 4 = 0.

Optional Feature:
- BRANCH_RESOLVE_PERF_EN defined:
  - Adds outputs perf_branches_o [31:0], perf_mispredicts_o [31:0] and perf_drops_o [31:0].
  - Counters cleared on reset, incrementing on each resolution (non-squashed, non-flushed), each emitted mispredict, and each drop.
  - Counters saturate at 32'hFFFFFFFF.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- pipe0 valid, source 0x100, taken=1, target 0x200, pred_taken=0 -> next cycle: branch_request_o=1, branch_is_taken_o=1, branch_pc_o=0x200, source 0x100; queue unchanged.
- pipe0 correct not-taken at 0x100 plus pipe1 mispredicted taken at 0x104 (target 0x300, pred target 0x280) -> cycle+1: request for 0x104 with pc 0x300; cycle+2: training-only not_taken for 0x100 with pc 0x104.
- pipe0 mispredict plus pipe1 valid -> only the pipe0 event emitted; pipe1 never appears and the queue count is unchanged.
- 3 consecutive cycles of 2 correct resolutions with depth 4 and pops active -> queue fills; exactly the excess younger entries drop with queue_drop_o pulses; the emitted order matches the push order.
- flush_i=1 with a pipe0 mispredict -> no request emitted; a previously queued entry still pops next cycle.
- rst_i asserted with a non-empty queue and pending output -> next cycle all strobes 0 and the queue is empty. With BRANCH_RESOLVE_PERF_EN, all counters read 0.

Source files
------------

// File: rtl/biriscv_branch_resolve.sv
// Branch resolution: turns the two execute pipes' resolved branches into predictor redirect/training updates.
// Optional build macro BRANCH_RESOLVE_PERF_EN adds saturating branch/mispredict/drop counters.
module biriscv_branch_resolve #(
    parameter int QUEUE_DEPTH   = 4,
    parameter int QUEUE_DEPTH_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,

    input  logic        pipe0_valid_i,
    input  logic [31:0] pipe0_source_i,
    input  logic        pipe0_taken_i,
    input  logic [31:0] pipe0_target_i,
    input  logic        pipe0_is_call_i,
    input  logic        pipe0_is_ret_i,
    input  logic        pipe0_is_jmp_i,
    input  logic        pipe0_pred_taken_i,
    input  logic [31:0] pipe0_pred_target_i,

    input  logic        pipe1_valid_i,
    input  logic [31:0] pipe1_source_i,
    input  logic        pipe1_taken_i,
    input  logic [31:0] pipe1_target_i,
    input  logic        pipe1_is_call_i,
    input  logic        pipe1_is_ret_i,
    input  logic        pipe1_is_jmp_i,
    input  logic        pipe1_pred_taken_i,
    input  logic [31:0] pipe1_pred_target_i,

    output logic        branch_request_o,
    output logic        branch_is_taken_o,
    output logic        branch_is_not_taken_o,
    output logic [31:0] branch_source_o,
    output logic [31:0] branch_pc_o,
    output logic        branch_is_call_o,
    output logic        branch_is_ret_o,
    output logic        branch_is_jmp_o,
    output logic        queue_drop_o
`ifdef BRANCH_RESOLVE_PERF_EN
    ,
    output logic [31:0] perf_branches_o,
    output logic [31:0] perf_mispredicts_o,
    output logic [31:0] perf_drops_o
`endif
);

    localparam int CNT_W = QUEUE_DEPTH_W + 1;
    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] TWO = ONE + ONE;

    typedef struct packed {
        logic [31:0] source;
        logic [31:0] pc;
        logic        taken;
        logic        is_call;
        logic        is_ret;
        logic        is_jmp;
    } entry_t;

    function automatic logic is_mispredict(
        input logic        valid,
        input logic        taken,
        input logic [31:0] target,
        input logic        pred_taken,
        input logic [31:0] pred_target
    );
        return valid & ((taken != pred_taken) | (taken & (target != pred_target)));
    endfunction

    function automatic logic [31:0] resolve_pc(
        input logic        taken,
        input logic [31:0] source,
        input logic [31:0] target
    );
        return taken ? target : (source + 32'd4);
    endfunction

    entry_t                   mem_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [QUEUE_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic        request_q, request_d;
    logic        taken_q, taken_d;
    logic        not_taken_q, not_taken_d;
    logic [31:0] source_q, source_d;
    logic [31:0] pc_q, pc_d;
    logic        call_q, call_d;
    logic        ret_q, ret_d;
    logic        jmp_q, jmp_d;
    logic        drop_q, drop_d;

    logic                     v0_s, v1_s, mis0_s, mis1_raw_s, mis1_s, mis_any_s;
    logic                     ok0_s, ok1_s, acc0_s, acc1_s, drop0_s, drop1_s, pop_s;
    logic [CNT_W:0]           free_s;
    logic [QUEUE_DEPTH_W-1:0] wr_idx1_s;
    entry_t                   e0_s, e1_s, mis_e_s, head_s;

    // Classify this cycle's resolutions and decide queue push/pop/drop.
    always_comb begin
        v0_s       = pipe0_valid_i & ~flush_i;
        v1_s       = pipe1_valid_i & ~flush_i;
        mis0_s     = is_mispredict(v0_s, pipe0_taken_i, pipe0_target_i,
                                   pipe0_pred_taken_i, pipe0_pred_target_i);
        mis1_raw_s = is_mispredict(v1_s, pipe1_taken_i, pipe1_target_i,
                                   pipe1_pred_taken_i, pipe1_pred_target_i);
        // An older mispredict squashes the younger pipe entirely.
        mis1_s     = mis1_raw_s & ~mis0_s;
        mis_any_s  = mis0_s | mis1_s;
        ok0_s      = v0_s & ~mis0_s;
        ok1_s      = v1_s & ~mis0_s & ~mis1_raw_s;

        e0_s.source  = pipe0_source_i;
        e0_s.pc      = resolve_pc(pipe0_taken_i, pipe0_source_i, pipe0_target_i);
        e0_s.taken   = pipe0_taken_i;
        e0_s.is_call = pipe0_is_call_i;
        e0_s.is_ret  = pipe0_is_ret_i;
        e0_s.is_jmp  = pipe0_is_jmp_i;
        e1_s.source  = pipe1_source_i;
        e1_s.pc      = resolve_pc(pipe1_taken_i, pipe1_source_i, pipe1_target_i);
        e1_s.taken   = pipe1_taken_i;
        e1_s.is_call = pipe1_is_call_i;
        e1_s.is_ret  = pipe1_is_ret_i;
        e1_s.is_jmp  = pipe1_is_jmp_i;
        mis_e_s      = mis0_s ? e0_s : e1_s;
        head_s       = mem_q[rd_ptr_q];

        pop_s   = (count_q != {CNT_W{1'b0}}) & ~mis_any_s;
        free_s  = (CNT_W+1)'(QUEUE_DEPTH) - (CNT_W+1)'(count_q) + (CNT_W+1)'(pop_s);
        acc0_s  = ok0_s & (free_s >= ONE);
        acc1_s  = ok1_s & (free_s >= (acc0_s ? TWO : ONE));
        drop0_s = ok0_s & ~acc0_s;
        drop1_s = ok1_s & ~acc1_s;

        wr_idx1_s = wr_ptr_q + QUEUE_DEPTH_W'(acc0_s);
        wr_ptr_d  = wr_ptr_q + QUEUE_DEPTH_W'(acc0_s) + QUEUE_DEPTH_W'(acc1_s);
        rd_ptr_d  = rd_ptr_q + QUEUE_DEPTH_W'(pop_s);
        count_d   = count_q + CNT_W'(acc0_s) + CNT_W'(acc1_s) - CNT_W'(pop_s);
    end

    // Output slot: mispredict first, otherwise the queue head, otherwise idle with data held.
    always_comb begin
        source_d    = source_q;
        pc_d        = pc_q;
        call_d      = call_q;
        ret_d       = ret_q;
        jmp_d       = jmp_q;
        request_d   = 1'b0;
        taken_d     = 1'b0;
        not_taken_d = 1'b0;
        drop_d      = drop0_s | drop1_s;
        if (mis_any_s) begin
            request_d   = 1'b1;
            taken_d     = mis_e_s.taken;
            not_taken_d = ~mis_e_s.taken;
            source_d    = mis_e_s.source;
            pc_d        = mis_e_s.pc;
            call_d      = mis_e_s.is_call;
            ret_d       = mis_e_s.is_ret;
            jmp_d       = mis_e_s.is_jmp;
        end else if (pop_s) begin
            request_d   = 1'b0;
            taken_d     = head_s.taken;
            not_taken_d = ~head_s.taken;
            source_d    = head_s.source;
            pc_d        = head_s.pc;
            call_d      = head_s.is_call;
            ret_d       = head_s.is_ret;
            jmp_d       = head_s.is_jmp;
        end else begin
            request_d   = 1'b0;
            taken_d     = 1'b0;
            not_taken_d = 1'b0;
        end
    end

    // Queue storage: contents need no reset, only pointers and count do.
    always_ff @(posedge clk_i) begin
        if (acc0_s) begin
            mem_q[wr_ptr_q] <= e0_s;
        end
        if (acc1_s) begin
            mem_q[wr_idx1_s] <= e1_s;
        end
    end

    // Queue control and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= {QUEUE_DEPTH_W{1'b0}};
            rd_ptr_q    <= {QUEUE_DEPTH_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            request_q   <= 1'b0;
            taken_q     <= 1'b0;
            not_taken_q <= 1'b0;
            source_q    <= 32'h0000_0000;
            pc_q        <= 32'h0000_0000;
            call_q      <= 1'b0;
            ret_q       <= 1'b0;
            jmp_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            request_q   <= request_d;
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
            source_q    <= source_d;
            pc_q        <= pc_d;
            call_q      <= call_d;
            ret_q       <= ret_d;
            jmp_q       <= jmp_d;
            drop_q      <= drop_d;
        end
    end

    assign branch_request_o      = request_q;
    assign branch_is_taken_o     = taken_q;
    assign branch_is_not_taken_o = not_taken_q;
    assign branch_source_o       = source_q;
    assign branch_pc_o           = pc_q;
    assign branch_is_call_o      = call_q;
    assign branch_is_ret_o       = ret_q;
    assign branch_is_jmp_o       = jmp_q;
    assign queue_drop_o          = drop_q;

`ifdef BRANCH_RESOLVE_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] value, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, value} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_mispredicts_q, perf_mispredicts_d;
    logic [31:0] perf_drops_q, perf_drops_d;

    // A pipe1 resolution squashed by an older mispredict is not counted.
    always_comb begin
        perf_branches_d    = sat_add(perf_branches_q,
                                     {1'b0, v0_s} + {1'b0, v1_s & ~mis0_s});
        perf_mispredicts_d = sat_add(perf_mispredicts_q, {1'b0, mis_any_s});
        perf_drops_d       = sat_add(perf_drops_q, {1'b0, drop0_s} + {1'b0, drop1_s});
    end

    // Performance counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_branches_q    <= 32'h0000_0000;
            perf_mispredicts_q <= 32'h0000_0000;
            perf_drops_q       <= 32'h0000_0000;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
            perf_drops_q       <= perf_drops_d;
        end
    end

    assign perf_branches_o    = perf_branches_q;
    assign perf_mispredicts_o = perf_mispredicts_q;
    assign perf_drops_o       = perf_drops_q;
`endif

endmodule

// File: tb/tb_biriscv_branch_resolve.sv
// Directed bench for biriscv_branch_resolve: hand-computed vectors checked with immediate assertions.
module tb_biriscv_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        p0_valid, p0_taken, p0_call, p0_ret, p0_jmp, p0_pred_taken;
    logic [31:0] p0_source, p0_target, p0_pred_target;
    logic        p1_valid, p1_taken, p1_call, p1_ret, p1_jmp, p1_pred_taken;
    logic [31:0] p1_source, p1_target, p1_pred_target;

    logic        branch_request_o, branch_is_taken_o, branch_is_not_taken_o;
    logic [31:0] branch_source_o, branch_pc_o;
    logic        branch_is_call_o, branch_is_ret_o, branch_is_jmp_o, queue_drop_o;
`ifdef BRANCH_RESOLVE_PERF_EN
    logic [31:0] perf_branches_o, perf_mispredicts_o, perf_drops_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    biriscv_branch_resolve #(.QUEUE_DEPTH(4), .QUEUE_DEPTH_W(2)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .flush_i              (flush),
        .pipe0_valid_i        (p0_valid),
        .pipe0_source_i       (p0_source),
        .pipe0_taken_i        (p0_taken),
        .pipe0_target_i       (p0_target),
        .pipe0_is_call_i      (p0_call),
        .pipe0_is_ret_i       (p0_ret),
        .pipe0_is_jmp_i       (p0_jmp),
        .pipe0_pred_taken_i   (p0_pred_taken),
        .pipe0_pred_target_i  (p0_pred_target),
        .pipe1_valid_i        (p1_valid),
        .pipe1_source_i       (p1_source),
        .pipe1_taken_i        (p1_taken),
        .pipe1_target_i       (p1_target),
        .pipe1_is_call_i      (p1_call),
        .pipe1_is_ret_i       (p1_ret),
        .pipe1_is_jmp_i       (p1_jmp),
        .pipe1_pred_taken_i   (p1_pred_taken),
        .pipe1_pred_target_i  (p1_pred_target),
        .branch_request_o     (branch_request_o),
        .branch_is_taken_o    (branch_is_taken_o),
        .branch_is_not_taken_o(branch_is_not_taken_o),
        .branch_source_o      (branch_source_o),
        .branch_pc_o          (branch_pc_o),
        .branch_is_call_o     (branch_is_call_o),
        .branch_is_ret_o      (branch_is_ret_o),
        .branch_is_jmp_o      (branch_is_jmp_o),
        .queue_drop_o         (queue_drop_o)
`ifdef BRANCH_RESOLVE_PERF_EN
        ,
        .perf_branches_o      (perf_branches_o),
        .perf_mispredicts_o   (perf_mispredicts_o),
        .perf_drops_o         (perf_drops_o)
`endif
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic req, input logic tk, input logic ntk,
                              input logic [31:0] src, input logic [31:0] pc, input logic drop);
        check32({tag, "_req"},  32'(branch_request_o),      32'(req));
        check32({tag, "_tk"},   32'(branch_is_taken_o),     32'(tk));
        check32({tag, "_ntk"},  32'(branch_is_not_taken_o), 32'(ntk));
        check32({tag, "_src"},  branch_source_o,            src);
        check32({tag, "_pc"},   branch_pc_o,                pc);
        check32({tag, "_drop"}, 32'(queue_drop_o),          32'(drop));
    endtask

    task automatic clear_inputs();
        p0_valid = 1'b0; p0_taken = 1'b0; p0_call = 1'b0; p0_ret = 1'b0; p0_jmp = 1'b0;
        p0_pred_taken = 1'b0; p0_source = 32'h0; p0_target = 32'h0; p0_pred_target = 32'h0;
        p1_valid = 1'b0; p1_taken = 1'b0; p1_call = 1'b0; p1_ret = 1'b0; p1_jmp = 1'b0;
        p1_pred_taken = 1'b0; p1_source = 32'h0; p1_target = 32'h0; p1_pred_target = 32'h0;
    endtask

    task automatic set_p0(input logic [31:0] src, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        p0_valid = 1'b1; p0_source = src; p0_taken = tk; p0_target = tgt;
        p0_pred_taken = ptk; p0_pred_target = ptgt;
    endtask

    task automatic set_p1(input logic [31:0] src, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        p1_valid = 1'b1; p1_source = src; p1_taken = tk; p1_target = tgt;
        p1_pred_taken = ptk; p1_pred_target = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;

        // Single pipe0 mispredict (taken, predicted not taken), flagged as a call.
        set_p0(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        p0_call = 1'b1;
        tick();
        expect_out("t1", 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 1'b0);
        check32("t1_call", 32'(branch_is_call_o), 32'd1);
        clear_inputs();
        tick();
        expect_out("t1_idle", 1'b0, 1'b0, 1'b0, 32'h100, 32'h200, 1'b0);

        // pipe0 correct not-taken, pipe1 target mispredict.
        set_p0(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        set_p1(32'h104, 1'b1, 32'h300, 1'b1, 32'h280);
        tick();
        expect_out("t2_req", 1'b1, 1'b1, 1'b0, 32'h104, 32'h300, 1'b0);
        clear_inputs();
        tick();
        expect_out("t2_train", 1'b0, 1'b0, 1'b1, 32'h100, 32'h104, 1'b0);
        tick();
        expect_out("t2_idle", 1'b0, 1'b0, 1'b0, 32'h100, 32'h104, 1'b0);

        // pipe0 mispredict squashes a correct pipe1.
        set_p0(32'h400, 1'b0, 32'h0, 1'b1, 32'h480);
        set_p1(32'h404, 1'b1, 32'h500, 1'b1, 32'h500);
        tick();
        expect_out("t3_req", 1'b1, 1'b0, 1'b1, 32'h400, 32'h404, 1'b0);
        clear_inputs();
        tick();
        expect_out("t3_squash", 1'b0, 1'b0, 1'b0, 32'h400, 32'h404, 1'b0);

        // Prefill two entries while mispredicts block pops, then three cycles of pairs.
        set_p0(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0);
        set_p1(32'h1004, 1'b1, 32'h2000, 1'b0, 32'h0);
        tick();
        expect_out("t4_p1", 1'b1, 1'b1, 1'b0, 32'h1004, 32'h2000, 1'b0);
        set_p0(32'h1100, 1'b0, 32'h0, 1'b0, 32'h0);
        set_p1(32'h1104, 1'b1, 32'h2100, 1'b0, 32'h0);
        tick();
        expect_out("t4_p2", 1'b1, 1'b1, 1'b0, 32'h1104, 32'h2100, 1'b0);
        set_p0(32'h3000, 1'b1, 32'h3800, 1'b1, 32'h3800);
        set_p1(32'h3004, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        expect_out("t4_a", 1'b0, 1'b0, 1'b1, 32'h1000, 32'h1004, 1'b0);
        set_p0(32'h3100, 1'b1, 32'h3900, 1'b1, 32'h3900);
        set_p1(32'h3104, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        expect_out("t4_b", 1'b0, 1'b0, 1'b1, 32'h1100, 32'h1104, 1'b0);
        set_p0(32'h3200, 1'b1, 32'h3A00, 1'b1, 32'h3A00);
        set_p1(32'h3204, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        expect_out("t4_c", 1'b0, 1'b1, 1'b0, 32'h3000, 32'h3800, 1'b1);
        clear_inputs();
        tick();
        expect_out("t4_d", 1'b0, 1'b0, 1'b1, 32'h3004, 32'h3008, 1'b0);
        tick();
        expect_out("t4_e", 1'b0, 1'b1, 1'b0, 32'h3100, 32'h3900, 1'b0);
        tick();
        expect_out("t4_f", 1'b0, 1'b0, 1'b1, 32'h3104, 32'h3108, 1'b0);
        tick();
        expect_out("t4_g", 1'b0, 1'b1, 1'b0, 32'h3200, 32'h3A00, 1'b0);
        tick();
        expect_out("t4_empty", 1'b0, 1'b0, 1'b0, 32'h3200, 32'h3A00, 1'b0);

        // Flushed mispredict is ignored; the queued entry still drains.
        set_p0(32'h5000, 1'b0, 32'h0, 1'b0, 32'h0);
        set_p1(32'h5004, 1'b1, 32'h6000, 1'b0, 32'h0);
        tick();
        expect_out("t5_req", 1'b1, 1'b1, 1'b0, 32'h5004, 32'h6000, 1'b0);
        clear_inputs();
        flush = 1'b1;
        set_p0(32'h7000, 1'b1, 32'h7100, 1'b0, 32'h0);
        tick();
        expect_out("t5_flush", 1'b0, 1'b0, 1'b1, 32'h5000, 32'h5004, 1'b0);
        flush = 1'b0;
        clear_inputs();
        tick();
        expect_out("t5_idle", 1'b0, 1'b0, 1'b0, 32'h5000, 32'h5004, 1'b0);

        // Not-taken at the top of the address space wraps source+4 to zero.
        set_p0(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
        tick();
        expect_out("t6_wrap", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
        clear_inputs();
        tick();
        expect_out("t6_idle", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);

        // Reset with a queued entry and a pending request.
        set_p0(32'h8000, 1'b0, 32'h0, 1'b0, 32'h0);
        set_p1(32'h8004, 1'b1, 32'h9000, 1'b0, 32'h0);
        tick();
        expect_out("t7_req", 1'b1, 1'b1, 1'b0, 32'h8004, 32'h9000, 1'b0);
        clear_inputs();
        rst = 1'b1;
        tick();
        expect_out("t7_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef BRANCH_RESOLVE_PERF_EN
        check32("t7_perf_br", perf_branches_o, 32'h0);
        check32("t7_perf_mis", perf_mispredicts_o, 32'h0);
        check32("t7_perf_drop", perf_drops_o, 32'h0);
`endif
        rst = 1'b0;
        tick();
        expect_out("t7_empty", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
